// File: rtl/cbx_param.sv
// Parametrised x-direction connection block: straight-through tracks plus per-pin tap muxes
// driven from a double-buffered serial configuration chain.
module cbx_param #(
  parameter int unsigned CHAN_W   = 12,
  parameter int unsigned NUM_IPIN = 9,
  parameter int unsigned MUX_SIZE = 8
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                ccff_en,
  input  logic                ccff_head,
  input  logic                ccff_commit,
  input  logic [CHAN_W-1:0]   chanx_left_in,
  input  logic [CHAN_W-1:0]   chanx_right_in,
  output logic [CHAN_W-1:0]   chanx_left_out,
  output logic [CHAN_W-1:0]   chanx_right_out,
  output logic [NUM_IPIN-1:0] ipin_out,
  output logic                ccff_tail,
  output logic                cfg_full,
  output logic                cfg_valid,
  output logic                cfg_err
);

  localparam int unsigned SEL_W    = $clog2(MUX_SIZE);
  localparam int unsigned FIELD_W  = SEL_W + 1;
  localparam int unsigned CFG_BITS = NUM_IPIN * FIELD_W;
  localparam int unsigned HALF     = MUX_SIZE / 2;
  localparam int unsigned STRIDE   = (CHAN_W - 2) / (HALF - 2);
  localparam int unsigned CNT_W    = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(CFG_BITS);

  if (CHAN_W < 4) begin : g_bad_chan_w
    $error("cbx_param: CHAN_W must be at least 4");
  end
  if ((MUX_SIZE < 6) || ((MUX_SIZE & (MUX_SIZE - 1)) != 0)) begin : g_bad_mux_size
    $error("cbx_param: MUX_SIZE must be a power of two and at least 6");
  end

  // Track index feeding mux input pair j of pin p; pins rotate through the stride window.
  function automatic int unsigned tap_idx(input int unsigned p, input int unsigned j);
    if (j == 0) return 0;
    if (j == 1) return 1;
    return (2 + (j - 2) * STRIDE + (p % STRIDE)) % CHAN_W;
  endfunction

  logic [CFG_BITS-1:0] sr_q, sr_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cfg_valid_q, cfg_valid_d;
  logic                cfg_err_q, cfg_err_d;

  assign chanx_right_out = chanx_left_in;
  assign chanx_left_out  = chanx_right_in;

  assign ccff_tail = sr_q[CFG_BITS-1];
  assign cfg_full  = (cnt_q == CntMax);
  assign cfg_valid = cfg_valid_q;
  assign cfg_err   = cfg_err_q;

  // Commit wins over shift so the captured image is exactly what was loaded.
  always_comb begin
    sr_d        = sr_q;
    active_d    = active_q;
    cnt_d       = cnt_q;
    cfg_valid_d = cfg_valid_q;
    cfg_err_d   = cfg_err_q;
    if (ccff_commit) begin
      if (cfg_full) begin
        active_d    = sr_q;
        cnt_d       = '0;
        cfg_valid_d = 1'b1;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (ccff_en) begin
      sr_d = {sr_q[CFG_BITS-2:0], ccff_head};
      if (!cfg_full) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      sr_q        <= '0;
      active_q    <= '0;
      cnt_q       <= '0;
      cfg_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      active_q    <= active_d;
      cnt_q       <= cnt_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  for (genvar i = 0; i < NUM_IPIN; i++) begin : g_pin
    logic [MUX_SIZE-1:0] mux_in;
    logic [SEL_W-1:0]    sel;
    logic                en;

    for (genvar j = 0; j < HALF; j++) begin : g_tap
      localparam int unsigned Track = tap_idx(i, j);
      assign mux_in[2*j]   = chanx_left_in[Track];
      assign mux_in[2*j+1] = chanx_right_in[Track];
    end

    assign sel = active_q[i*FIELD_W +: SEL_W];
    assign en  = active_q[i*FIELD_W + SEL_W];

    always_comb begin
      ipin_out[i] = en ? mux_in[sel] : 1'b0;
    end
  end

endmodule

// File: doc/cbx_param.md
# cbx_param

Parametrised x-direction connection block. It passes CHAN_W horizontal tracks straight through in both directions and drives NUM_IPIN grid input pins through configurable tap muxes. Its configuration chain is double-buffered: a serial shadow chain is loaded bit by bit, then committed atomically, so mux selects never change mid-load. It sits in the same chain position and grid slot as the existing fixed 12-track / 9-pin / size-8 connection blocks and replaces them when fabric size varies.

## Interface
- CHAN_W, 12, tracks per direction; must be ≥ 4.
- NUM_IPIN, 9, number of grid pins driven.
- MUX_SIZE, 8, inputs per pin mux; even, power of 2, ≥ 6.
- SEL_W, clog2(MUX_SIZE), select bits per mux (derived).
- CFG_BITS, NUM_IPIN*(SEL_W+1), chain length (derived).
- prog_clk  in  1  configuration clock; the only clock.
- pReset  in  1  asynchronous, active-high reset.
- ccff_en  in  1  shift enable for the shadow chain.
- ccff_head  in  1  serial config data in.
- ccff_commit  in  1  one-cycle pulse that copies the shadow chain to the active config.
- chanx_left_in, chanx_right_in  in  CHAN_W each  incoming tracks.
- chanx_left_out, chanx_right_out  out  CHAN_W each  outgoing tracks.
- ipin_out  out  NUM_IPIN  grid pin drives, bit i = pin i.
- ccff_tail  out  1  serial config out, equal to sr[CFG_BITS-1].
- cfg_full  out  1  shift count since last commit ≥ CFG_BITS.
- cfg_valid  out  1  at least one successful commit since reset.
- cfg_err  out  1  sticky: a commit was rejected.

## Operation
- Pass-through:
  - chanx_right_out = chanx_left_in.
  - chanx_left_out = chanx_right_in.
  - Both are combinational and unaffected by config or reset.
- Mux inputs for pin i, with H = MUX_SIZE/2:
  - Input 2j = chanx_left_in[t_j] and input 2j+1 = chanx_right_in[t_j], for j = 0..H-1.
  - t_0 = 0, t_1 = 1.
  - For j ≥ 2: t_j = (2 + (j-2)*S + (i mod S)) mod CHAN_W, where S = (CHAN_W-2)/(H-2) using integer division.
  - With the defaults, pin 0 taps tracks {0,1,2,7} and pin 5 taps tracks {0,1,2,7}.
- Config field for pin i: F = SEL_W+1 bits.
  - Bits i*F+0 .. i*F+SEL_W-1 hold the select, LSB first.
  - Bit i*F+SEL_W is the enable.
  - ipin_out[i] = enable ? in[sel] : 0, combinational from the active register.
- Shadow chain sr[0:CFG_BITS-1]:
  - When ccff_en=1 and no commit: sr[0] ← ccff_head and sr[k] ← sr[k-1].
  - The last bit shifted lands in pin 0, select bit 0.
- Shift counter cnt, width clog2(CFG_BITS+1):
  - Increments on each shift and saturates at CFG_BITS.
  - cfg_full = (cnt == CFG_BITS).
  - Shifting past CFG_BITS is legal: old bits fall out of ccff_tail and the counter stays saturated.
- Commit, sampled at the prog_clk edge:
  - If cfg_full: active ← sr, cnt ← 0, cfg_valid ← 1.
  - Otherwise: active is unchanged, cnt is unchanged, cfg_err ← 1 (sticky until reset).
- ccff_en and ccff_commit in the same cycle: the commit has priority and the shift is suppressed that cycle. sr, ccff_tail and cnt are evaluated without that shift.
- sr is never cleared by a commit; the chain can be read back through ccff_tail by shifting.

## Timing
- Reset values while pReset=1 (asynchronous, immediate):
  - sr = 0, active = 0, cnt = 0.
  - cfg_full = 0, cfg_valid = 0, cfg_err = 0, ccff_tail = 0.
  - ipin_out = 0, because all enables are 0.
- Chain latency: ccff_head sampled at edge n appears on ccff_tail after edge n+CFG_BITS-1.
- Commit latency: active and ipin_out select change after the commit edge. cfg_full drops and cfg_valid rises at the same edge.
- Channel-to-ipin and pass-through paths are purely combinational, zero cycles.
- Reset asserted mid-load or mid-commit: everything clears immediately and the partial load is discarded. The first edge after deassertion behaves like a fresh start.

## Test plan
- Reset with random channel inputs:
  - ipin_out = 0, ccff_tail = 0, cfg_full/cfg_valid/cfg_err = 0.
  - chanx_right_out mirrors chanx_left_in, e.g. 12'hA5C → 12'hA5C.
- Default parameters: shift 36 bits so that pin 0 = {en=1, sel=6}, i.e. 4'b1110 with the enable as MSB, and all other pins = 0; then commit.
  - Before the commit: ipin_out = 0 throughout the load.
  - After the commit: ipin_out[0] follows chanx_left_in[7], other pins are 0, cfg_valid = 1.
- Shift 35 bits then commit:
  - cfg_err = 1 and ipin_out is unchanged.
  - 1 more shift then commit succeeds; cfg_err stays 1.
- ccff_en=1 and ccff_commit=1 in the same cycle with cfg_full=1:
  - The commit takes the pre-shift sr.
  - cnt = 0 and ccff_tail is unchanged that cycle.
- Shift a 36-bit pattern, then shift 36 more zeros: ccff_tail replays the original pattern in order; cnt stays saturated at 36.
- CHAN_W=20, NUM_IPIN=4, MUX_SIZE=16:
  - S = 3, so pin 2 taps tracks {0,1,4,7,10,13,16,19}.
  - sel=15 with en=1 drives chanx_right_in[19].
  - Pulse pReset mid-load: all outputs clear and a subsequent partial commit sets cfg_err.
